// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO serial config chain.
// Field offsets match the gpio control block's config word layout.
package gpio_cfg_pkg;

  localparam int NUM_IO_DEF   = 38;
  localparam int CFG_BITS_DEF = 13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_SHIFT,
    S_LOAD
  } state_e;

  localparam int CFG_MGMT_EN    = 0;
  localparam int CFG_OUT_DIS    = 1;
  localparam int CFG_HOLD_OVR   = 2;
  localparam int CFG_INP_DIS    = 3;
  localparam int CFG_MODE_SEL   = 4;
  localparam int CFG_ANA_EN     = 5;
  localparam int CFG_ANA_SEL    = 6;
  localparam int CFG_ANA_POL    = 7;
  localparam int CFG_SLOW       = 8;
  localparam int CFG_VTRIP_SEL  = 9;
  localparam int CFG_DM_LSB     = 10;
  localparam int CFG_DM_W       = 3;

endpackage

// File: rtl/gpio_serial_cfg_sequencer_if.sv
// Control / register-file / chain signals of the config sequencer.
// master drives requests and read data; slave is the sequencer.
interface gpio_serial_cfg_sequencer_if #(
  parameter int NUM_IO   = 38,
  parameter int CFG_BITS = 13
);
  localparam int AW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;

  logic                start;
  logic                abort;
  logic                busy;
  logic                done;
  logic [AW-1:0]       cfg_addr;
  logic [CFG_BITS-1:0] cfg_data;
  logic                serial_clock;
  logic                serial_data_out;
  logic                serial_load;

  modport master (
    output start, abort, cfg_data,
    input  busy, done, cfg_addr,
    input  serial_clock, serial_data_out,
    input  serial_load
  );

  modport slave (
    input  start, abort, cfg_data,
    output busy, done, cfg_addr,
    output serial_clock, serial_data_out,
    output serial_load
  );

endinterface

// File: rtl/gpio_cfg_tick_gen.sv
// Phase divider: one-cycle tick every CLK_DIV enabled cycles.
// Reloads on restart and on each tick so phases start aligned.
module gpio_cfg_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_restart,
  output logic o_tick
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && !i_restart && (r_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= RELOAD;
    end else if (i_restart || o_tick) begin
      r_cnt <= RELOAD;
    end else if (i_en) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/gpio_serial_cfg_sequencer.sv
// Fetches one config word per pad and shifts the chain out,
// last pad first, MSB first, then pulses serial_load.
module gpio_serial_cfg_sequencer
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_IO   = NUM_IO_DEF,
  parameter int CFG_BITS = CFG_BITS_DEF,
  parameter int CLK_DIV  = 4
) (
  input  logic                        clock,
  input  logic                        resetn,
  gpio_serial_cfg_sequencer_if.slave  bus
);
  localparam int AW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam logic [AW-1:0] PAD_LAST = AW'(NUM_IO - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CFG_BITS - 1);

  state_e              r_state;
  logic [AW-1:0]       r_pad;
  logic [BW-1:0]       r_bit;
  logic [CFG_BITS-1:0] r_shreg;
  logic                r_busy;
  logic                r_done;
  logic                r_sclk;
  logic                r_sdo;
  logic                r_load;
  logic                w_div_en;
  logic                w_tick;

  assign w_div_en = (r_state == S_SHIFT) || (r_state == S_LOAD);

  gpio_cfg_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk     (clock),
    .i_rst_n   (resetn),
    .i_en      (w_div_en),
    .i_restart (!w_div_en),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_pad   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_sdo   <= 1'b0;
      r_load  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE && bus.abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_sclk  <= 1'b0;
        r_load  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (bus.start && !bus.abort) begin
              r_state <= S_ADDR;
              r_busy  <= 1'b1;
              r_pad   <= PAD_LAST;
            end
          end
          S_ADDR: begin
            r_state <= S_DATA;
          end
          S_DATA: begin
            r_shreg <= bus.cfg_data;
            r_sdo   <= bus.cfg_data[CFG_BITS-1];
            r_bit   <= BIT_LAST;
            r_sclk  <= 1'b0;
            r_state <= S_SHIFT;
          end
          S_SHIFT: begin
            if (w_tick && !r_sclk) begin
              r_sclk <= 1'b1;
            end else if (w_tick) begin
              // falling edge: next bit goes out
              r_sclk  <= 1'b0;
              r_shreg <= r_shreg << 1;
              r_sdo   <= r_shreg[CFG_BITS-2];
              r_bit   <= r_bit - 1'b1;
              if (r_bit == '0 && r_pad == '0) begin
                r_state <= S_LOAD;
                r_load  <= 1'b1;
              end else if (r_bit == '0) begin
                r_pad   <= r_pad - 1'b1;
                r_state <= S_ADDR;
              end
            end
          end
          S_LOAD: begin
            if (w_tick) begin
              r_load  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.cfg_addr        = r_pad;
  assign bus.serial_clock    = r_sclk;
  assign bus.serial_data_out = r_sdo;
  assign bus.serial_load     = r_load;

endmodule

// File: tb/tb_gpio_serial_cfg_sequencer.sv
// Bench: small (2x4, div 1) and full-size (38x13, div 3) sequencers
// against a pad-chain model with shift registers and a load latch.
module tb_gpio_serial_cfg_sequencer;

  localparam int S_N = 2, S_B = 4, S_D = 1;
  localparam int L_N = 38, L_B = 13, L_D = 3;
  localparam int S_BUSY = S_N * (2 + 2 * S_D * S_B) + S_D;
  localparam int L_BUSY = L_N * (2 + 2 * L_D * L_B) + L_D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  gpio_serial_cfg_sequencer_if #(.NUM_IO(S_N), .CFG_BITS(S_B)) sb ();
  gpio_serial_cfg_sequencer_if #(.NUM_IO(L_N), .CFG_BITS(L_B)) lb ();

  gpio_serial_cfg_sequencer #(
    .NUM_IO(S_N), .CFG_BITS(S_B), .CLK_DIV(S_D)
  ) u_small (
    .clock  (clk),
    .resetn (rst_n),
    .bus    (sb)
  );

  gpio_serial_cfg_sequencer #(
    .NUM_IO(L_N), .CFG_BITS(L_B), .CLK_DIV(L_D)
  ) u_large (
    .clock  (clk),
    .resetn (rst_n),
    .bus    (lb)
  );

  logic [S_B-1:0] s_mem [S_N];
  logic [L_B-1:0] l_mem [L_N];

  always @(posedge clk) sb.cfg_data <= s_mem[sb.cfg_addr];
  always @(posedge clk) lb.cfg_data <= l_mem[lb.cfg_addr];

  int s_busy, s_done, s_load, s_rise;
  logic [S_N*S_B-1:0] s_chain = '0;
  logic [S_N*S_B-1:0] s_latch = '0;
  logic s_pclk = 1'b0, s_pload = 1'b0;

  always @(negedge clk) begin
    if (sb.busy === 1'b1) s_busy++;
    if (sb.done === 1'b1) s_done++;
    if (sb.serial_load === 1'b1) s_load++;
    if (sb.serial_clock === 1'b1 && !s_pclk) begin
      s_rise++;
      s_chain = {s_chain[S_N*S_B-2:0], sb.serial_data_out};
    end
    if (sb.serial_load === 1'b1 && !s_pload) s_latch = s_chain;
    s_pclk  = (sb.serial_clock === 1'b1);
    s_pload = (sb.serial_load === 1'b1);
  end

  int l_busy, l_done, l_load, l_rise, l_hbad, l_lcd;
  int l_run = 0;
  logic [L_N*L_B-1:0] l_chain = '0;
  logic [L_N*L_B-1:0] l_latch = '0;
  logic l_pclk = 1'b0, l_pload = 1'b0;

  always @(negedge clk) begin
    if (lb.busy === 1'b1) l_busy++;
    if (lb.done === 1'b1) l_done++;
    if (lb.serial_load === 1'b1) l_load++;
    if (lb.serial_clock === 1'b1 && !l_pclk) begin
      l_rise++;
      l_chain = {l_chain[L_N*L_B-2:0], lb.serial_data_out};
    end
    if (lb.serial_load === 1'b1 && !l_pload) l_latch = l_chain;
    if ((lb.serial_clock === 1'b1) != l_pclk) begin
      if (l_pclk && l_run != L_D) l_hbad++;
      if (!l_pclk && l_run == L_D) l_lcd++;
      l_run = 1;
    end else begin
      l_run++;
    end
    l_pclk  = (lb.serial_clock === 1'b1);
    l_pload = (lb.serial_load === 1'b1);
  end

  task automatic s_clear();
    s_busy = 0; s_done = 0; s_load = 0; s_rise = 0;
  endtask

  task automatic s_xfer(input logic [S_B-1:0] m1,
                        input logic [S_B-1:0] m0,
                        input int restart_at,
                        input string tag);
    int k;
    s_mem[1] = m1;
    s_mem[0] = m0;
    s_clear();
    sb.start = 1'b1;
    k = 0;
    while (k < 200) begin
      step();
      k++;
      sb.start = (k == restart_at);
      if (sb.done === 1'b1) break;
    end
    sb.start = 1'b0;
    chk({tag, "_done_at"}, 64'(k), 64'(S_BUSY + 1));
    step();
    step();
    chk({tag, "_busy_cyc"}, 64'(s_busy), 64'(S_BUSY));
    chk({tag, "_done_cnt"}, 64'(s_done), 64'd1);
    chk({tag, "_load_cyc"}, 64'(s_load), 64'(S_D));
    chk({tag, "_rises"}, 64'(s_rise), 64'(S_N * S_B));
    chk({tag, "_bits"}, 64'(s_chain), 64'({m1, m0}));
    chk({tag, "_latch"}, 64'(s_latch), 64'({m1, m0}));
  endtask

  task automatic s_abort(input int at, input string tag);
    logic [S_N*S_B-1:0] old;
    old = s_latch;
    s_mem[1] = 4'($urandom);
    s_mem[0] = 4'($urandom);
    s_clear();
    sb.start = 1'b1;
    for (int k = 1; k <= at; k++) begin
      step();
      sb.start = 1'b0;
    end
    sb.abort = 1'b1;
    step();
    sb.abort = 1'b0;
    chk({tag, "_busy"}, 64'(sb.busy), 64'd0);
    chk({tag, "_sclk"}, 64'(sb.serial_clock), 64'd0);
    repeat (30) step();
    chk({tag, "_busy_cyc"}, 64'(s_busy), 64'(at));
    chk({tag, "_no_load"}, 64'(s_load), 64'd0);
    chk({tag, "_no_done"}, 64'(s_done), 64'd0);
    chk({tag, "_latch"}, 64'(s_latch), 64'(old));
  endtask

  initial begin
    int k;
    logic [S_N*S_B-1:0] old;
    sb.start = 1'b0;
    sb.abort = 1'b0;
    lb.start = 1'b0;
    lb.abort = 1'b0;
    for (int i = 0; i < S_N; i++) s_mem[i] = '0;
    for (int i = 0; i < L_N; i++) l_mem[i] = '0;

    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_small", 64'({sb.busy, sb.done, sb.serial_clock,
        sb.serial_data_out, sb.serial_load, sb.cfg_addr}), 64'd0);
    chk("rst_large", 64'({lb.busy, lb.done, lb.serial_clock,
        lb.serial_data_out, lb.serial_load, lb.cfg_addr}), 64'd0);

    s_xfer(4'hA, 4'h3, 0, "basic");
    for (int t = 0; t < 3; t++)
      s_xfer(4'($urandom), 4'($urandom), 0, "rand");
    s_xfer(4'($urandom), 4'($urandom), 5, "restart");

    s_abort(13, "abort_b5lo");
    s_abort(14, "abort_b5hi");
    for (int t = 0; t < 3; t++)
      s_abort(int'($urandom_range(1, S_BUSY - 1)), "abort_rand");

    s_clear();
    sb.start = 1'b1;
    sb.abort = 1'b1;
    step();
    sb.start = 1'b0;
    sb.abort = 1'b0;
    chk("abort_start_idle", 64'(sb.busy), 64'd0);
    repeat (5) step();
    chk("abort_start_cyc", 64'(s_busy), 64'd0);

    old = s_latch;
    s_mem[1] = 4'($urandom);
    s_mem[0] = 4'($urandom);
    s_clear();
    sb.start = 1'b1;
    step();
    sb.start = 1'b0;
    repeat (3) step();
    chk("rst_mid_sclk_hi", 64'(sb.serial_clock), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", 64'({sb.busy, sb.done, sb.serial_clock,
        sb.serial_data_out, sb.serial_load, sb.cfg_addr}), 64'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("rst_mid_no_load", 64'(s_load), 64'd0);
    chk("rst_mid_latch", 64'(s_latch), 64'(old));
    s_xfer(4'($urandom), 4'($urandom), 0, "after_rst");

    for (int i = 0; i < L_N; i++) l_mem[i] = 13'($urandom);
    l_busy = 0; l_done = 0; l_load = 0; l_rise = 0;
    l_hbad = 0; l_lcd = 0;
    lb.start = 1'b1;
    k = 0;
    while (k < 6000) begin
      step();
      k++;
      lb.start = 1'b0;
      if (lb.done === 1'b1) break;
    end
    step();
    chk("big_done_at", 64'(k), 64'(L_BUSY + 1));
    chk("big_busy_cyc", 64'(l_busy), 64'(L_BUSY));
    chk("big_done_cnt", 64'(l_done), 64'd1);
    chk("big_load_cyc", 64'(l_load), 64'(L_D));
    chk("big_rises", 64'(l_rise), 64'(L_N * L_B));
    chk("big_hi_phase", 64'(l_hbad), 64'd0);
    chk("big_lo_phase", 64'(l_lcd), 64'(L_N * (L_B - 1)));
    for (int i = 0; i < L_N; i++)
      chk($sformatf("big_pad%0d", i),
          64'(l_latch[i*L_B +: L_B]), 64'(l_mem[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
